textlcd_axil_ctrl: RTL and testbench
====================================

Name: textlcd_axil_ctrl

Overview:
AXI4-Lite slave that drives an HD44780-style character LCD. It is the parametrised successor of the 4-register textlcd peripheral: software pushes LCD commands and characters into a write FIFO. A timing sequencer then drains the FIFO onto the LCD pins with programmable setup, enable-pulse and execution-wait timing. It supports an 8-bit or 4-bit LCD bus and has a status/overflow interrupt.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32).
C_S_AXI_ADDR_WIDTH, 4, AXI address width; 4 registers at 0x0/0x4/0x8/0xC.
FIFO_DEPTH, 16, command FIFO entries; power of two, 2..256.
LCD_BUS_WIDTH, 8, LCD data bus width: 8 (one transfer per entry) or 4 (two nibble transfers).
TIMING_RST, 32'h000A_0402, reset value of the TIMING register.
LONG_MULT, 40, wait multiplier for clear/home commands.

Ports:
S_AXI_ACLK  in  1  the single clock.
S_AXI_ARESET  in  1  reset; one clock; reset is synchronous and active-high.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  write byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response (always OKAY).
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
lcd_rs  out  1  LCD register select.
lcd_rw  out  1  LCD read/write; tied 0.
lcd_e  out  1  LCD enable strobe.
lcd_data  out  LCD_BUS_WIDTH  LCD data bus.
irq  out  1  level interrupt: CTRL.ie & (FIFO empty & engine idle, or overflow).

Behaviour:
- Reset values: all READY/VALID outputs 0; BRESP, RDATA and all lcd_* outputs 0; irq 0; FIFO empty; CTRL 0; TIMING = TIMING_RST; overflow flag 0.
- Reset mid-operation: lcd_e goes low on the reset edge. The FIFO is discarded and any AXI response in progress is dropped.
- AXI write:
  - AWREADY and WREADY assert together for 1 cycle when AWVALID & WVALID & !BVALID.
  - BVALID asserts the next cycle and is held until BREADY.
  - Only one write and one read are outstanding at a time.
- AXI read:
  - ARREADY is a 1-cycle pulse when ARVALID & !RVALID.
  - RDATA/RVALID follow the next cycle and are held until RREADY.
  - Unmapped bits read 0.
- Byte strobes are honoured on CTRL and TIMING.
- 0x0 CTRL (RW):
  - bit0 enable.
  - bit1 flush: self-clearing; empties the FIFO next cycle; an in-flight LCD transfer completes.
  - bit2 ie (interrupt enable).
- 0x4 STATUS (RO except bit3):
  - bit0 busy (engine not IDLE).
  - bit1 empty, bit2 full.
  - bit3 overflow: sticky, write-1-to-clear.
  - [15:8] FIFO level.
- 0x8 TX (WO, reads 0): a write with WSTRB[0]=1 pushes {WDATA[8]=rs, WDATA[7:0]=data}.
  - Push while full: entry dropped, overflow set, BRESP=2'b10 (SLVERR).
  - All other writes: BRESP=OKAY.
  - Simultaneous push and engine pop when full: the pop frees the slot, so the push succeeds.
- 0xC TIMING (RW): [7:0] setup S, [15:8] pulse P, [31:16] wait W, all in clocks. S=0 or P=0 is treated as 1; W=0 means no wait.
- Engine FSM IDLE -> SETUP -> PULSE -> HOLD -> (NIBBLE -> SETUP) -> WAIT -> IDLE:
  - IDLE: if enable & !empty, pop the entry; latch lcd_rs and lcd_data (high nibble in 4-bit mode); go to SETUP.
  - SETUP: S cycles with lcd_e=0.
  - PULSE: P cycles with lcd_e=1.
  - HOLD: 1 cycle with lcd_e=0 and data stable.
  - 4-bit mode: after the first HOLD, drive the low nibble and repeat SETUP/PULSE/HOLD.
  - WAIT: W cycles. If rs=0 and data in {0x01,0x02,0x03}, wait W*LONG_MULT cycles instead (saturating 24-bit counter).
  - Back-to-back entries: IDLE lasts 1 cycle between entries.
- Latency: TX handshake at edge t writes the FIFO. Pop and lcd_rs/lcd_data update at edge t+1. lcd_e rises at edge t+1+S and stays high for exactly P cycles.
- Enable cleared mid-transfer: the current entry finishes, then the engine holds in IDLE.
- lcd_rs and lcd_data change only in IDLE or NIBBLE.

Decomposition:
- textlcd_pkg holds:
  - register offset localparams;
  - CTRL/STATUS bit indices;
  - the engine state enum;
  - the RESP_OKAY/RESP_SLVERR constants;
  - function is_long_cmd(rs, data).
- One sub-module: textlcd_fifo, a synchronous FIFO (width 9, depth FIFO_DEPTH, level/full/empty outputs, flush input, push-while-full ignored).

Test Plan:
1. Release reset -> all outputs 0; reads return CTRL=0, STATUS=0x0000_0002, TIMING=0x000A_0402.
2. Write TIMING=0x0005_0302 with WSTRB=4'b0011 -> reads back 0x000A_0302. Read address 0x8 -> 0, OKAY.
3. LCD_BUS_WIDTH=8, TIMING S=2/P=4/W=10, enable, TX=0x141 -> lcd_rs=1, data=0x41; lcd_e high exactly 4 cycles starting 3 cycles after the handshake; busy cleared 2+4+1+10+1 cycles later.
4. LCD_BUS_WIDTH=4, TX=0x141 -> two pulses, lcd_data=4'h4 then 4'h1, rs=1 on both.
5. Enable=0, 17 TX writes, depth 16:
   - 17th write -> BRESP=2'b10; STATUS full=1, overflow=1, level=16; irq=1 with ie.
   - Write STATUS=0x8 -> overflow clears.
   - Flush -> empty=1.
6. TX=0x001, W=10 -> WAIT lasts 400 cycles. Assert reset during PULSE of the next entry -> lcd_e=0 next edge and STATUS=0x2 after release.

Source files
------------

// File: rtl/textlcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : textlcd_pkg
// Description : Shared constants for the AXI4-Lite character LCD controller:
//               register offsets, CTRL/STATUS bit positions, engine state
//               encoding, AXI response codes and the long-command helper.
// Revision    : 1.0 - initial release
// ============================================================================
package textlcd_pkg;

  // Register byte offsets (word aligned)
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_TX     = 4'h8;
  localparam logic [3:0] OFF_TIMING = 4'hC;

  // CTRL bits
  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_IE    = 2;

  // STATUS bits
  localparam int STAT_BUSY      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_FULL      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_LEVEL_LSB = 8;

  // Engine states
  typedef logic [2:0] eng_state_t;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_PULSE  = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_NIBBLE = 3'd4;
  localparam logic [2:0] ST_WAIT   = 3'd5;

  // AXI responses
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Clear display (0x01) and return home (0x02/0x03) need a much longer
  // execution time than every other HD44780 instruction.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

endpackage
`default_nettype wire

// File: rtl/textlcd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : textlcd_fifo
// Description : Synchronous show-ahead FIFO for LCD command entries.
//               A push while full is ignored unless a pop happens in the
//               same cycle. flush_i empties the FIFO.
// Ports       : clk_i, rst_i, flush_i, push_i/data_i, pop_i/data_o,
//               level_o, full_o, empty_o
// Revision    : 1.0 - initial release
// ============================================================================
module textlcd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        data_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LVL);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/textlcd_axil_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : textlcd_axil_ctrl
// Description : AXI4-Lite slave driving an HD44780-style character LCD.
//               Software pushes commands/characters into a FIFO; a timing
//               engine drains it onto the LCD pins with programmable setup,
//               enable-pulse and execution-wait times (8- or 4-bit bus).
// Ports       : S_AXI_* AXI4-Lite slave (clock/sync reset included),
//               lcd_rs/lcd_rw/lcd_e/lcd_data LCD pins, irq level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module textlcd_axil_ctrl #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          FIFO_DEPTH         = 16,
  parameter int          LCD_BUS_WIDTH      = 8,
  parameter logic [31:0] TIMING_RST         = 32'h000A_0402,
  parameter int          LONG_MULT          = 40
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            lcd_rs,
  output logic                            lcd_rw,
  output logic                            lcd_e,
  output logic [LCD_BUS_WIDTH-1:0]        lcd_data,
  output logic                            irq
);
  import textlcd_pkg::*;

  // ---------------- register file / AXI state ----------------
  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]  bresp_q;
  logic [31:0] rdata_q, rdata_d;
  logic        en_q, flush_q, ie_q, ovf_q;
  logic [31:0] timing_q;
  logic [3:0]  wr_off, rd_off;
  logic        wr_hs, rd_hs, tx_req, tx_drop, busy;
  logic        unused_addr_bits;

  // ---------------- FIFO ----------------
  logic                           fifo_pop, fifo_full, fifo_empty;
  logic [8:0]                     fifo_dout;
  logic [$clog2(FIFO_DEPTH):0]    fifo_level;
  logic [8:0]                     level9;
  logic [7:0]                     level8;

  // ---------------- engine ----------------
  logic [2:0]                state_q, state_d;
  logic [23:0]               cnt_q, cnt_d;
  logic                      rs_q, rs_d, e_q, e_d, nib_q, nib_d;
  logic [7:0]                byte_q, byte_d;
  logic [LCD_BUS_WIDTH-1:0]  data_q, data_d, first_bus, second_bus;
  logic [23:0]               setup_ld, pulse_ld, wait_len;
  logic [31:0]               long_prod;

  assign wr_off = {S_AXI_AWADDR[3:2], 2'b00};
  assign rd_off = {S_AXI_ARADDR[3:2], 2'b00};
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // awready_q only rises while both valids are present, and AXI masters
  // must hold them, so wr_hs always completes the transfer it announced.
  assign wr_hs   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs   = arready_q & S_AXI_ARVALID;
  assign tx_req  = wr_hs & (wr_off == OFF_TX) & S_AXI_WSTRB[0];
  assign tx_drop = tx_req & fifo_full & ~fifo_pop;
  assign busy    = (state_q != ST_IDLE);

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;
  assign lcd_data = data_q;
  assign irq      = ie_q & ((fifo_empty & ~busy) | ovf_q);

  // A full 256-deep FIFO cannot show its level in 8 bits; saturate.
  assign level9 = 9'(fifo_level);
  assign level8 = level9[8] ? 8'hFF : level9[7:0];

  textlcd_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (S_AXI_ACLK),
    .rst_i   (S_AXI_ARESET),
    .flush_i (flush_q),
    .push_i  (tx_req),
    .data_i  (S_AXI_WDATA[8:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- AXI write / register updates ----------------
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      en_q      <= 1'b0;
      flush_q   <= 1'b0;
      ie_q      <= 1'b0;
      ovf_q     <= 1'b0;
      timing_q  <= TIMING_RST;
    end else begin
      awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
      flush_q   <= 1'b0;
      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= tx_drop ? RESP_SLVERR : RESP_OKAY;
        case (wr_off)
          OFF_CTRL: if (S_AXI_WSTRB[0]) begin
            en_q    <= S_AXI_WDATA[CTRL_EN];
            flush_q <= S_AXI_WDATA[CTRL_FLUSH];
            ie_q    <= S_AXI_WDATA[CTRL_IE];
          end
          OFF_STATUS: if (S_AXI_WSTRB[0] && S_AXI_WDATA[STAT_OVF]) ovf_q <= 1'b0;
          OFF_TIMING: begin
            for (int i = 0; i < 4; i++) begin
              if (S_AXI_WSTRB[i]) timing_q[8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
          end
          default: ;
        endcase
      end
      if (tx_drop) ovf_q <= 1'b1;
    end
  end

  // ---------------- AXI read ----------------
  always_comb begin
    rdata_d = '0;
    case (rd_off)
      OFF_CTRL: begin
        rdata_d[CTRL_EN]    = en_q;
        rdata_d[CTRL_FLUSH] = flush_q;
        rdata_d[CTRL_IE]    = ie_q;
      end
      OFF_STATUS: begin
        rdata_d[STAT_BUSY]              = busy;
        rdata_d[STAT_EMPTY]             = fifo_empty;
        rdata_d[STAT_FULL]              = fifo_full;
        rdata_d[STAT_OVF]               = ovf_q;
        rdata_d[STAT_LEVEL_LSB +: 8]    = level8;
      end
      OFF_TIMING: rdata_d = timing_q;
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
      if (rvalid_q && S_AXI_RREADY) rvalid_q <= 1'b0;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end
    end
  end

  // ---------------- LCD timing engine ----------------
  generate
    if (LCD_BUS_WIDTH == 4) begin : g_bus4
      assign first_bus  = fifo_dout[7:4];
      assign second_bus = byte_q[3:0];
    end else begin : g_bus8
      assign first_bus  = fifo_dout[7:0];
      assign second_bus = byte_q;
    end
  endgenerate

  // Counters are loaded with (length - 1); a zero S or P still gives one cycle.
  assign setup_ld  = (timing_q[7:0]  == 8'd0) ? 24'd0 : {16'd0, timing_q[7:0]  - 8'd1};
  assign pulse_ld  = (timing_q[15:8] == 8'd0) ? 24'd0 : {16'd0, timing_q[15:8] - 8'd1};
  assign long_prod = 32'(timing_q[31:16]) * 32'(LONG_MULT);
  assign wait_len  = is_long_cmd(rs_q, byte_q)
                   ? ((long_prod[31:24] != 8'd0) ? 24'hFF_FFFF : long_prod[23:0])
                   : {8'd0, timing_q[31:16]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rs_d     = rs_q;
    byte_d   = byte_q;
    data_d   = data_q;
    e_d      = e_q;
    nib_d    = nib_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: if (en_q && !fifo_empty) begin
        fifo_pop = 1'b1;
        rs_d     = fifo_dout[8];
        byte_d   = fifo_dout[7:0];
        data_d   = first_bus;
        nib_d    = 1'b0;
        cnt_d    = setup_ld;
        state_d  = ST_SETUP;
      end
      ST_SETUP: if (cnt_q == '0) begin
        state_d = ST_PULSE;
        e_d     = 1'b1;
        cnt_d   = pulse_ld;
      end else cnt_d = cnt_q - 24'd1;
      ST_PULSE: if (cnt_q == '0) begin
        state_d = ST_HOLD;
        e_d     = 1'b0;
      end else cnt_d = cnt_q - 24'd1;
      ST_HOLD: begin
        if (LCD_BUS_WIDTH == 4 && !nib_q) state_d = ST_NIBBLE;
        else if (wait_len == '0)          state_d = ST_IDLE;
        else begin
          state_d = ST_WAIT;
          cnt_d   = wait_len - 24'd1;
        end
      end
      ST_NIBBLE: begin
        data_d  = second_bus;
        nib_d   = 1'b1;
        cnt_d   = setup_ld;
        state_d = ST_SETUP;
      end
      ST_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
               else cnt_d = cnt_q - 24'd1;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      byte_q  <= '0;
      data_q  <= '0;
      e_q     <= 1'b0;
      nib_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      e_q     <= e_d;
      nib_q   <= nib_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_textlcd_axil_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_textlcd_axil_ctrl
// Description : Directed self-checking bench for textlcd_axil_ctrl. An 8-bit
//               and a 4-bit instance share one AXI master; LCD pins of both
//               are observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_textlcd_axil_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [31:0] wdata;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        lcd_rs8, lcd_rw8, lcd_e8, irq8;
  logic [7:0]  lcd_data8;

  logic        awready4, wready4, bvalid4, arready4, rvalid4;
  logic [1:0]  bresp4, rresp4;
  logic [31:0] rdata4;
  logic        lcd_rs4, lcd_rw4, lcd_e4, irq4;
  logic [3:0]  lcd_data4;

  int n_checks = 0;
  int n_errors = 0;

  textlcd_axil_ctrl #(.LCD_BUS_WIDTH(8)) dut8 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .lcd_rs(lcd_rs8), .lcd_rw(lcd_rw8), .lcd_e(lcd_e8), .lcd_data(lcd_data8), .irq(irq8)
  );

  textlcd_axil_ctrl #(.LCD_BUS_WIDTH(4)) dut4 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready4),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready4),
    .S_AXI_BRESP(bresp4), .S_AXI_BVALID(bvalid4), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready4),
    .S_AXI_RDATA(rdata4), .S_AXI_RRESP(rresp4), .S_AXI_RVALID(rvalid4), .S_AXI_RREADY(rready),
    .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_e(lcd_e4), .lcd_data(lcd_data4), .irq(irq4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the write handshake edge.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    n = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && n < 50) begin step(); n++; end
    if (!awready) check("awready_timeout", 32'(awready), 32'd1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin step(); n++; end
    if (!bvalid) check("bvalid_timeout", 32'(bvalid), 32'd1);
    resp = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    n = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 50) begin step(); n++; end
    if (!arready) check("arready_timeout", 32'(arready), 32'd1);
    step();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin step(); n++; end
    if (!rvalid) check("rvalid_timeout", 32'(rvalid), 32'd1);
    data = rdata; resp = rresp;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int first_e, e_cnt, irq_k, irq4_k, rises4, ok_cnt;
    logic prev_e4, rs41, rs42;
    logic [3:0] nib1, nib2;

    rst = 1'b1;
    awaddr = '0; araddr = '0; wstrb = '0; wdata = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // ---- 1: reset state ----
    check("reset_outs8", 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp,
                               lcd_rs8, lcd_rw8, lcd_e8, irq8, lcd_data8}), 32'd0);
    check("reset_outs4", 32'({awready4, wready4, bvalid4, bresp4, arready4, rvalid4, rresp4,
                               lcd_rs4, lcd_rw4, lcd_e4, irq4, lcd_data4}), 32'd0);
    check("reset_rdata8", rdata, 32'd0);
    check("reset_rdata4", rdata4, 32'd0);
    axi_read(4'h0, rd, rsp); check("rst_ctrl", rd, 32'h0);
    axi_read(4'h4, rd, rsp); check("rst_status", rd, 32'h0000_0002);
    axi_read(4'hC, rd, rsp); check("rst_timing", rd, 32'h000A_0402);

    // ---- 2: strobed TIMING write, TX reads 0 ----
    axi_write(4'hC, 32'h0005_0302, 4'b0011, rsp); check("timing_wr_resp", 32'(rsp), 32'd0);
    axi_read(4'hC, rd, rsp); check("timing_strobe", rd, 32'h000A_0302);
    axi_read(4'h8, rd, rsp); check("tx_read_zero", rd, 32'h0);
    check("tx_read_resp", 32'(rsp), 32'd0);

    // ---- 3/4: single character, S=2 P=4 W=10 ----
    axi_write(4'hC, 32'h000A_0402, 4'hF, rsp);
    axi_write(4'h0, 32'h0000_0005, 4'h1, rsp);
    check("irq_idle_empty", 32'(irq8), 32'd1);
    axi_write(4'h8, 32'h0000_0141, 4'h1, rsp);
    check("tx_resp_ok", 32'(rsp), 32'd0);
    check("lcd_rs8", 32'(lcd_rs8), 32'd1);
    check("lcd_data8", 32'(lcd_data8), 32'h41);
    first_e = 0; e_cnt = 0; irq_k = 0; irq4_k = 0; rises4 = 0; prev_e4 = 1'b0;
    nib1 = '0; nib2 = '0; rs41 = 1'b0; rs42 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) step();
      if (lcd_e8) begin
        if (first_e == 0) first_e = k;
        e_cnt++;
      end
      if (irq8 && irq_k == 0) irq_k = k;
      if (irq4 && irq4_k == 0) irq4_k = k;
      if (lcd_e4 && !prev_e4) begin
        rises4++;
        if (rises4 == 1) begin nib1 = lcd_data4; rs41 = lcd_rs4; end
        else begin nib2 = lcd_data4; rs42 = lcd_rs4; end
      end
      prev_e4 = lcd_e4;
    end
    check("e8_rise_cycle", 32'(first_e), 32'd3);
    check("e8_high_cycles", 32'(e_cnt), 32'd4);
    check("busy8_clear_cycle", 32'(irq_k), 32'd18);
    check("lcd_data8_stable", 32'(lcd_data8), 32'h41);
    check("e4_pulses", 32'(rises4), 32'd2);
    check("nib_hi", 32'(nib1), 32'h4);
    check("nib_lo", 32'(nib2), 32'h1);
    check("nib_rs", 32'({rs41, rs42}), 32'b11);
    check("busy4_clear_cycle", 32'(irq4_k), 32'd26);

    // ---- 5: overflow with engine disabled ----
    axi_write(4'h0, 32'h0000_0004, 4'h1, rsp);
    ok_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      axi_write(4'h8, 32'h100 + 32'(i), 4'h1, rsp);
      if (rsp == 2'b00) ok_cnt++;
    end
    check("tx_16_ok", 32'(ok_cnt), 32'd16);
    axi_write(4'h8, 32'h0000_0155, 4'h1, rsp);
    check("tx_17_slverr", 32'(rsp), 32'd2);
    axi_read(4'h4, rd, rsp); check("status_full_ovf", rd, 32'h0000_100C);
    check("irq_ovf", 32'(irq8), 32'd1);
    axi_write(4'h4, 32'h0000_0008, 4'h1, rsp);
    axi_read(4'h4, rd, rsp); check("status_ovf_clr", rd, 32'h0000_1004);
    check("irq_after_clr", 32'(irq8), 32'd0);
    axi_write(4'h0, 32'h0000_0006, 4'h1, rsp);
    axi_read(4'h4, rd, rsp); check("status_flushed", rd, 32'h0000_0002);
    axi_read(4'h0, rd, rsp); check("ctrl_flush_selfclr", rd, 32'h0000_0004);

    // ---- 6: long command, then reset mid-pulse ----
    axi_write(4'h0, 32'h0000_0005, 4'h1, rsp);
    axi_write(4'h8, 32'h0000_0001, 4'h1, rsp);
    check("long_rs", 32'(lcd_rs8), 32'd0);
    irq_k = 0; irq4_k = 0;
    for (int k = 1; k <= 420; k++) begin
      if (k > 1) step();
      if (irq8 && irq_k == 0) irq_k = k;
      if (irq4 && irq4_k == 0) irq4_k = k;
    end
    check("long_wait8", 32'(irq_k), 32'd408);
    check("long_wait4", 32'(irq4_k), 32'd416);
    axi_write(4'h8, 32'h0000_0141, 4'h1, rsp);
    repeat (3) step();
    check("pulse_e8", 32'(lcd_e8), 32'd1);
    check("pulse_e4", 32'(lcd_e4), 32'd1);
    rst = 1'b1;
    step();
    check("rst_e8_low", 32'(lcd_e8), 32'd0);
    check("rst_e4_low", 32'(lcd_e4), 32'd0);
    rst = 1'b0;
    step();
    axi_read(4'h4, rd, rsp); check("status_after_rst", rd, 32'h0000_0002);
    axi_read(4'h0, rd, rsp); check("ctrl_after_rst", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
